// File: rtl/rob.sv
// rob: 2**ROB_WIDTH-entry reorder buffer with in-order retire, operand lookup and mispredict flush.
module rob #(
  parameter int ROB_WIDTH = 3
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 dec_ready,
  input  logic [1:0]           dec_type,
  input  logic [4:0]           dec_rd,
  input  logic                 dec_pred_taken,
  input  logic [31:0]          dec_alt_pc,
  output logic [ROB_WIDTH-1:0] dec_rob_id,
  output logic                 rob_full,
  input  logic [ROB_WIDTH-1:0] query_j_id,
  input  logic [ROB_WIDTH-1:0] query_k_id,
  output logic                 query_j_ready,
  output logic                 query_k_ready,
  output logic [31:0]          query_j_value,
  output logic [31:0]          query_k_value,
  input  logic                 rs_ready,
  input  logic [ROB_WIDTH-1:0] rs_rob_id,
  input  logic [31:0]          rs_value,
  input  logic                 lsb_ready,
  input  logic [ROB_WIDTH-1:0] lsb_rob_id,
  input  logic [31:0]          lsb_value,
  output logic                 commit_valid,
  output logic [ROB_WIDTH-1:0] commit_rob_id,
  output logic [4:0]           commit_rd,
  output logic [31:0]          commit_value,
  output logic                 store_commit,
  output logic                 clear,
  output logic [31:0]          clear_pc
);
  localparam int DEPTH = 1 << ROB_WIDTH;
  logic [DEPTH-1:0]     busy, rdy, pred;
  logic [1:0]           typ    [DEPTH];
  logic [4:0]           rd     [DEPTH];
  logic [31:0]          alt_pc [DEPTH];
  logic [31:0]          value  [DEPTH];
  logic [ROB_WIDTH-1:0] head, tail;
  logic [ROB_WIDTH:0]   count;
  logic                 cv_q, sc_q, clr_q;
  logic                 dispatch, retire, mispredict, rs_hit, lsb_hit;
  logic                 jr, jl, kr, kl, j_done, k_done;
  assign rob_full      = count == (ROB_WIDTH+1)'(DEPTH);
  assign dec_rob_id    = tail;
  assign commit_valid  = cv_q && rdy_in;
  assign store_commit  = sc_q && rdy_in;
  assign clear         = clr_q && rdy_in;
  assign dispatch      = dec_ready && !rob_full && !clr_q;
  assign retire        = busy[head] && rdy[head];
  assign mispredict    = retire && typ[head] == 2'b10 && value[head][0] != pred[head];
  assign rs_hit        = rs_ready && !clr_q && busy[rs_rob_id];
  assign lsb_hit       = lsb_ready && !clr_q && busy[lsb_rob_id];
  // Lookups prefer the stored result, then a same-cycle broadcast (LSB over RS).
  assign j_done        = busy[query_j_id] && rdy[query_j_id];
  assign k_done        = busy[query_k_id] && rdy[query_k_id];
  assign jl            = lsb_hit && lsb_rob_id == query_j_id;
  assign jr            = rs_hit && rs_rob_id == query_j_id;
  assign kl            = lsb_hit && lsb_rob_id == query_k_id;
  assign kr            = rs_hit && rs_rob_id == query_k_id;
  assign query_j_ready = j_done || jl || jr;
  assign query_k_ready = k_done || kl || kr;
  assign query_j_value = j_done ? value[query_j_id] : jl ? lsb_value : jr ? rs_value : 32'd0;
  assign query_k_value = k_done ? value[query_k_id] : kl ? lsb_value : kr ? rs_value : 32'd0;
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      busy          <= '0;
      rdy           <= '0;
      cv_q          <= 1'b0;
      sc_q          <= 1'b0;
      clr_q         <= 1'b0;
      commit_rob_id <= '0;
      commit_rd     <= '0;
      commit_value  <= '0;
      clear_pc      <= '0;
    end else if (!rdy_in) begin
      cv_q  <= 1'b0;
      sc_q  <= 1'b0;
      clr_q <= 1'b0;
    end else begin
      cv_q  <= retire && typ[head] == 2'b00;
      sc_q  <= retire && typ[head] == 2'b01;
      clr_q <= mispredict;
      if (retire) begin
        commit_rob_id <= head;
        commit_rd     <= rd[head];
        commit_value  <= value[head];
        busy[head]    <= 1'b0;
        head          <= head + 1'b1;
      end
      if (mispredict) clear_pc <= alt_pc[head];
      if (dispatch) begin
        busy[tail]   <= 1'b1;
        rdy[tail]    <= 1'b0;
        typ[tail]    <= dec_type == 2'b11 ? 2'b00 : dec_type;
        rd[tail]     <= dec_rd;
        pred[tail]   <= dec_pred_taken;
        alt_pc[tail] <= dec_alt_pc;
        tail         <= tail + 1'b1;
      end
      if (rs_hit) begin
        rdy[rs_rob_id]   <= 1'b1;
        value[rs_rob_id] <= rs_value;
      end
      if (lsb_hit) begin
        rdy[lsb_rob_id]   <= 1'b1;
        value[lsb_rob_id] <= lsb_value;
      end
      count <= count + {{ROB_WIDTH{1'b0}}, dispatch} - {{ROB_WIDTH{1'b0}}, retire};
      if (mispredict) begin
        busy  <= '0;
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end
    end
  end
endmodule

// File: tb/tb_rob.sv
// tb_rob: scenario tasks plus a commit scoreboard that pops expected retirements in program order.
module tb_rob;
  logic        clk_in = 1'b0, rst_in = 1'b1, rdy_in = 1'b1;
  logic        dec_ready = 1'b0, dec_pred_taken = 1'b0;
  logic [1:0]  dec_type = 2'b00;
  logic [4:0]  dec_rd = 5'd0;
  logic [31:0] dec_alt_pc = 32'd0;
  logic [2:0]  dec_rob_id, query_j_id = 3'd0, query_k_id = 3'd0;
  logic        rob_full, query_j_ready, query_k_ready;
  logic [31:0] query_j_value, query_k_value;
  logic        rs_ready = 1'b0, lsb_ready = 1'b0;
  logic [2:0]  rs_rob_id = 3'd0, lsb_rob_id = 3'd0;
  logic [31:0] rs_value = 32'd0, lsb_value = 32'd0;
  logic        commit_valid, store_commit, clear;
  logic [2:0]  commit_rob_id;
  logic [4:0]  commit_rd;
  logic [31:0] commit_value, clear_pc;
  int tests = 0, fails = 0;
  typedef struct {
    logic        st;
    logic [2:0]  id;
    logic [4:0]  rd;
    logic [31:0] val;
  } exp_t;
  exp_t q[$];

  rob #(.ROB_WIDTH(3)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .dec_ready(dec_ready), .dec_type(dec_type), .dec_rd(dec_rd),
    .dec_pred_taken(dec_pred_taken), .dec_alt_pc(dec_alt_pc),
    .dec_rob_id(dec_rob_id), .rob_full(rob_full),
    .query_j_id(query_j_id), .query_k_id(query_k_id),
    .query_j_ready(query_j_ready), .query_k_ready(query_k_ready),
    .query_j_value(query_j_value), .query_k_value(query_k_value),
    .rs_ready(rs_ready), .rs_rob_id(rs_rob_id), .rs_value(rs_value),
    .lsb_ready(lsb_ready), .lsb_rob_id(lsb_rob_id), .lsb_value(lsb_value),
    .commit_valid(commit_valid), .commit_rob_id(commit_rob_id),
    .commit_rd(commit_rd), .commit_value(commit_value),
    .store_commit(store_commit), .clear(clear), .clear_pc(clear_pc)
  );

  always #5 clk_in = ~clk_in;

  always @(negedge clk_in) begin
    exp_t e;
    if (!rst_in && (commit_valid || store_commit)) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL commit_unexpected: valid=%0b store=%0b id=%0d, required no retirement", commit_valid, store_commit, commit_rob_id);
      end else begin
        e = q.pop_front();
        if (store_commit !== e.st || commit_valid !== !e.st || commit_rob_id !== e.id ||
            (!e.st && (commit_rd !== e.rd || commit_value !== e.val))) begin
          fails++;
          $display("FAIL commit_data: got st=%0b v=%0b id=%0d rd=%0d val=%h, required st=%0b id=%0d rd=%0d val=%h",
                   store_commit, commit_valid, commit_rob_id, commit_rd, commit_value, e.st, e.id, e.rd, e.val);
        end
      end
    end
  end

  task automatic do_reset();
    rst_in = 1'b1;
    repeat (2) @(posedge clk_in);
    #1 rst_in = 1'b0;
    q.delete();
  endtask

  task automatic do_dispatch(input logic [1:0] t, input logic [4:0] r, input logic p, input logic [31:0] a);
    dec_ready = 1'b1; dec_type = t; dec_rd = r; dec_pred_taken = p; dec_alt_pc = a;
    @(posedge clk_in);
    #1 dec_ready = 1'b0;
  endtask

  task automatic do_rs(input logic [2:0] id, input logic [31:0] v);
    rs_ready = 1'b1; rs_rob_id = id; rs_value = v;
    @(posedge clk_in);
    #1 rs_ready = 1'b0;
  endtask

  task automatic do_lsb(input logic [2:0] id, input logic [31:0] v);
    lsb_ready = 1'b1; lsb_rob_id = id; lsb_value = v;
    @(posedge clk_in);
    #1 lsb_ready = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 30 && q.size() != 0; i++) @(negedge clk_in);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL %s_drain: %0d retirements outstanding, required 0", name, q.size());
    end
  endtask

  task automatic test_reset();
    do_reset();
    repeat (2) @(negedge clk_in);
    tests++;
    if (rob_full !== 1'b0 || dec_rob_id !== 3'd0 || commit_valid !== 1'b0 || clear !== 1'b0 ||
        store_commit !== 1'b0 || clear_pc !== 32'd0 || commit_rob_id !== 3'd0 || commit_value !== 32'd0) begin
      fails++;
      $display("FAIL reset_outputs: full=%0b id=%0d cv=%0b clr=%0b sc=%0b pc=%h, required all 0",
               rob_full, dec_rob_id, commit_valid, clear, store_commit, clear_pc);
    end
  endtask

  task automatic test_basic();
    do_reset();
    do_dispatch(2'b00, 5'd5, 1'b0, 32'd0);
    tests++;
    if (dec_rob_id !== 3'd1) begin fails++; $display("FAIL basic_tail: got %0d, required 1", dec_rob_id); end
    q.push_back('{1'b0, 3'd0, 5'd5, 32'h1234});
    do_rs(3'd0, 32'h1234);
    @(negedge clk_in);
    tests++;
    if (commit_valid !== 1'b0) begin fails++; $display("FAIL basic_early: commit_valid=%0b, required 0", commit_valid); end
    @(negedge clk_in);
    tests++;
    if (commit_valid !== 1'b1) begin fails++; $display("FAIL basic_latency: commit_valid=%0b, required 1", commit_valid); end
    @(negedge clk_in);
    tests++;
    if (commit_valid !== 1'b0) begin fails++; $display("FAIL basic_pulse: commit_valid=%0b, required 0", commit_valid); end
    wait_drain("basic");
  endtask

  task automatic test_full_wrap();
    do_reset();
    for (int i = 0; i < 8; i++) do_dispatch(2'b00, 5'(i), 1'b0, 32'd0);
    tests++;
    if (rob_full !== 1'b1 || dec_rob_id !== 3'd0) begin
      fails++; $display("FAIL full_flag: full=%0b id=%0d, required 1 and 0", rob_full, dec_rob_id);
    end
    do_dispatch(2'b00, 5'd31, 1'b0, 32'd0);
    tests++;
    if (dec_rob_id !== 3'd0 || rob_full !== 1'b1) begin
      fails++; $display("FAIL full_drop: id=%0d full=%0b, required 0 and 1", dec_rob_id, rob_full);
    end
    q.push_back('{1'b0, 3'd0, 5'd0, 32'h100});
    do_rs(3'd0, 32'h100);
    @(posedge clk_in);
    #1;
    tests++;
    if (rob_full !== 1'b0 || dec_rob_id !== 3'd0) begin
      fails++; $display("FAIL full_release: full=%0b id=%0d, required 0 and 0", rob_full, dec_rob_id);
    end
    do_dispatch(2'b11, 5'd20, 1'b0, 32'd0);
    tests++;
    if (dec_rob_id !== 3'd1 || rob_full !== 1'b1) begin
      fails++; $display("FAIL wrap_alloc: id=%0d full=%0b, required 1 and 1", dec_rob_id, rob_full);
    end
    for (int i = 1; i < 8; i++) q.push_back('{1'b0, 3'(i), 5'(i), 32'h100 + i});
    q.push_back('{1'b0, 3'd0, 5'd20, 32'h200});
    for (int i = 1; i < 8; i++) do_rs(3'(i), 32'h100 + i);
    do_lsb(3'd0, 32'h200);
    wait_drain("full");
  endtask

  task automatic test_back_to_back();
    do_reset();
    do_dispatch(2'b00, 5'd1, 1'b0, 32'd0);
    do_dispatch(2'b01, 5'd2, 1'b0, 32'd0);
    do_lsb(3'd1, 32'h22);
    repeat (3) begin
      @(negedge clk_in);
      tests++;
      if (commit_valid !== 1'b0 || store_commit !== 1'b0) begin
        fails++; $display("FAIL ooo_hold: cv=%0b sc=%0b, required 0 0", commit_valid, store_commit);
      end
    end
    q.push_back('{1'b0, 3'd0, 5'd1, 32'h11});
    q.push_back('{1'b1, 3'd1, 5'd2, 32'h22});
    do_rs(3'd0, 32'h11);
    repeat (2) @(negedge clk_in);
    tests++;
    if (commit_valid !== 1'b1 || commit_rob_id !== 3'd0) begin
      fails++; $display("FAIL b2b_first: cv=%0b id=%0d, required 1 and 0", commit_valid, commit_rob_id);
    end
    @(negedge clk_in);
    tests++;
    if (store_commit !== 1'b1 || commit_valid !== 1'b0 || commit_rob_id !== 3'd1) begin
      fails++; $display("FAIL b2b_second: sc=%0b cv=%0b id=%0d, required 1 0 1", store_commit, commit_valid, commit_rob_id);
    end
    wait_drain("b2b");
  endtask

  task automatic test_mispredict();
    do_reset();
    do_dispatch(2'b10, 5'd0, 1'b0, 32'h100);
    do_dispatch(2'b00, 5'd3, 1'b0, 32'd0);
    do_dispatch(2'b00, 5'd4, 1'b0, 32'd0);
    do_rs(3'd1, 32'h1);
    do_rs(3'd2, 32'h2);
    do_rs(3'd0, 32'h1);
    @(negedge clk_in);
    tests++;
    if (clear !== 1'b0) begin fails++; $display("FAIL clear_early: clear=%0b, required 0", clear); end
    @(negedge clk_in);
    tests++;
    if (clear !== 1'b1 || clear_pc !== 32'h100 || dec_rob_id !== 3'd0 || rob_full !== 1'b0) begin
      fails++; $display("FAIL clear_pulse: clear=%0b pc=%h id=%0d, required 1 00000100 0", clear, clear_pc, dec_rob_id);
    end
    do_dispatch(2'b00, 5'd8, 1'b0, 32'd0);
    tests++;
    if (dec_rob_id !== 3'd0 || clear !== 1'b0) begin
      fails++; $display("FAIL clear_block: id=%0d clear=%0b, required 0 and 0", dec_rob_id, clear);
    end
    repeat (5) @(negedge clk_in);
    do_dispatch(2'b00, 5'd9, 1'b0, 32'd0);
    tests++;
    if (dec_rob_id !== 3'd1) begin fails++; $display("FAIL clear_realloc: id=%0d, required 1", dec_rob_id); end
    q.push_back('{1'b0, 3'd0, 5'd9, 32'h99});
    do_rs(3'd0, 32'h99);
    wait_drain("mispredict");
  endtask

  task automatic test_query();
    do_reset();
    for (int i = 0; i < 4; i++) do_dispatch(2'b00, 5'(i + 10), 1'b0, 32'd0);
    query_j_id = 3'd3; query_k_id = 3'd2;
    rs_ready = 1'b1; rs_rob_id = 3'd3; rs_value = 32'hAA;
    lsb_ready = 1'b1; lsb_rob_id = 3'd3; lsb_value = 32'hBB;
    #1;
    tests++;
    if (query_j_ready !== 1'b1 || query_j_value !== 32'hBB || query_k_ready !== 1'b0) begin
      fails++; $display("FAIL query_bypass: j=%0b/%h k=%0b, required 1/000000bb 0", query_j_ready, query_j_value, query_k_ready);
    end
    @(posedge clk_in);
    #1 lsb_ready = 1'b0; rs_rob_id = 3'd2; rs_value = 32'hCC;
    #1;
    tests++;
    if (query_j_ready !== 1'b1 || query_j_value !== 32'hBB || query_k_ready !== 1'b1 || query_k_value !== 32'hCC) begin
      fails++; $display("FAIL query_stored: j=%0b/%h k=%0b/%h, required 1/bb 1/cc", query_j_ready, query_j_value, query_k_ready, query_k_value);
    end
    @(posedge clk_in);
    #1 rs_rob_id = 3'd6; rs_value = 32'h66;
    @(posedge clk_in);
    #1 rs_ready = 1'b0; query_j_id = 3'd6;
    #1;
    tests++;
    if (query_j_ready !== 1'b0 || query_k_ready !== 1'b1 || query_k_value !== 32'hCC) begin
      fails++; $display("FAIL query_idle: j6=%0b k2=%0b/%h, required 0 1/cc", query_j_ready, query_k_ready, query_k_value);
    end
    q.push_back('{1'b0, 3'd0, 5'd10, 32'h10});
    q.push_back('{1'b0, 3'd1, 5'd11, 32'h11});
    q.push_back('{1'b0, 3'd2, 5'd12, 32'hCC});
    q.push_back('{1'b0, 3'd3, 5'd13, 32'hBB});
    do_lsb(3'd1, 32'h11);
    do_rs(3'd0, 32'h10);
    wait_drain("query");
  endtask

  task automatic test_pause();
    do_reset();
    do_dispatch(2'b00, 5'd7, 1'b0, 32'd0);
    q.push_back('{1'b0, 3'd0, 5'd7, 32'h77});
    do_rs(3'd0, 32'h77);
    rdy_in = 1'b0;
    repeat (3) begin
      @(negedge clk_in);
      tests++;
      if (commit_valid !== 1'b0 || q.size() != 1) begin
        fails++; $display("FAIL pause_hold: cv=%0b pending=%0d, required 0 1", commit_valid, q.size());
      end
    end
    rdy_in = 1'b1;
    wait_drain("pause");
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) do_dispatch(2'b00, 5'(i), 1'b0, 32'd0);
    do_rs(3'd1, 32'h55);
    rst_in = 1'b1;
    rs_ready = 1'b1; rs_rob_id = 3'd0; rs_value = 32'h44;
    @(posedge clk_in);
    #1 rst_in = 1'b0; rs_rob_id = 3'd1;
    @(posedge clk_in);
    #1 rs_ready = 1'b0; query_j_id = 3'd1;
    #1;
    tests++;
    if (dec_rob_id !== 3'd0 || rob_full !== 1'b0 || query_j_ready !== 1'b0) begin
      fails++; $display("FAIL reset_mid: id=%0d full=%0b q1=%0b, required 0 0 0", dec_rob_id, rob_full, query_j_ready);
    end
    repeat (4) @(negedge clk_in);
    tests++;
    if (clear !== 1'b0 || commit_valid !== 1'b0) begin
      fails++; $display("FAIL reset_mid_pulse: clear=%0b cv=%0b, required 0 0", clear, commit_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_wrap();
    test_back_to_back();
    test_mispredict();
    test_query();
    test_pause();
    test_reset_mid();
    repeat (2) @(negedge clk_in);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
